// File: rtl/bit_deserializer.sv
// bit_deserializer
//   Packs a qualified serial bit stream into WIDTH-bit words. Each word is
//   offered with its count of 1 bits on a valid/ready handshake. There is a
//   1-entry output register and a sticky overflow flag for dropped words.
//
// Ports
//   clk        : system clock; all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   bit_in     : serial data
//   bit_en     : sample qualifier for bit_in
//   clear      : synchronous flush of collector, output register and overflow
//   word_out   : assembled word, held stable until it is consumed
//   word_valid : output register holds an unconsumed word
//   word_ready : consumer accepts (transfer = word_valid & word_ready)
//   ones_cnt   : number of 1 bits in word_out
//   overflow   : sticky, set when a completed word was dropped
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_en,
    input  logic                       clear,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH+1)-1:0] ones_cnt,
    output logic                       overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    run_ones;
    logic [CW-1:0]    next_ones;
    logic             complete;
    logic             transfer;

    // next_word/next_ones already include the current bit, so on the
    // completion cycle they are exactly the word to be loaded.
    always_comb begin
        if (MSB_FIRST)
            next_word = {shift_reg[WIDTH-2:0], bit_in};
        else
            next_word = {bit_in, shift_reg[WIDTH-1:1]};
        next_ones = run_ones + CW'(bit_in);
        complete  = bit_en && (bit_cnt == LAST);
        transfer  = word_valid && word_ready;
    end

    // Collector: shift register, bit counter and running ones count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            run_ones  <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            run_ones  <= '0;
        end else if (bit_en) begin
            shift_reg <= next_word;
            if (complete) begin
                bit_cnt  <= '0;
                run_ones <= '0;
            end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                run_ones <= next_ones;
            end
        end
    end

    // Output FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            word_out   <= '0;
            ones_cnt   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            state      <= EMPTY;
            word_out   <= '0;
            ones_cnt   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (complete) begin
                        word_out   <= next_word;
                        ones_cnt   <= next_ones;
                        word_valid <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (transfer) begin
                        if (complete) begin
                            // Old word leaves as the new one arrives: no bubble.
                            word_out <= next_word;
                            ones_cnt <= next_ones;
                        end else begin
                            word_valid <= 1'b0;
                            state      <= EMPTY;
                        end
                    end else if (complete) begin
                        // Held word wins; the new one is dropped.
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_en;
    logic       clear;
    logic       word_ready;
    logic [7:0] w0, w1;
    logic       v0, v1;
    logic [3:0] o0, o1;
    logic       ovf0, ovf1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clear(clear),
        .word_out(w0), .word_valid(v0), .word_ready(word_ready),
        .ones_cnt(o0), .overflow(ovf0)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clear(clear),
        .word_out(w1), .word_valid(v1), .word_ready(word_ready),
        .ones_cnt(o1), .overflow(ovf1)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Expected words are queued as the stimulus is driven (first bit = v[7]).
    task automatic feed(input logic [7:0] v, input bit push);
        if (push) begin
            q0.push_back(v);
            q1.push_back(rev8(v));
        end
        for (int i = 0; i < 8; i++) begin
            bit_en = 1'b1;
            bit_in = v[7-i];
            @(posedge clk); #1;
        end
        bit_en = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic flush_sb;
        q0.delete();
        q1.delete();
    endtask

    // Scoreboard: a transfer happens at the next edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && !clear && v0 && word_ready) begin
            if (q0.size() == 0) chk("sb_msb_nonempty", q0.size(), 1);
            else begin
                logic [7:0] e;
                e = q0.pop_front();
                chk("sb_msb_word", w0, e);
                chk("sb_msb_ones", o0, $countones(e));
            end
        end
        if (!rst && !clear && v1 && word_ready) begin
            if (q1.size() == 0) chk("sb_lsb_nonempty", q1.size(), 1);
            else begin
                logic [7:0] e;
                e = q1.pop_front();
                chk("sb_lsb_word", w1, e);
                chk("sb_lsb_ones", o1, $countones(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic       early;

        rst = 1'b1; bit_in = 1'b0; bit_en = 1'b0; clear = 1'b0; word_ready = 1'b0;
        #12;
        chk("rst_word", w0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_ones", o0, 0);
        chk("rst_ovf", ovf0, 0);
        #4 rst = 1'b0;
        step();

        // Basic word, both bit orders
        word_ready = 1'b1;
        feed(8'hB2, 1'b1);
        chk("t1_valid", v0, 1);
        chk("t1_word_msb", w0, 8'hB2);
        chk("t1_ones_msb", o0, 4);
        chk("t1_word_lsb", w1, 8'h4D);
        chk("t1_ones_lsb", o1, 4);
        chk("t1_ovf", ovf0, 0);
        step();
        chk("t1_valid_one_cycle", v0, 0);

        // Backpressure overflow
        word_ready = 1'b0;
        feed(8'hFF, 1'b1);
        chk("t2_ovf_first", ovf0, 0);
        feed(8'h00, 1'b0);
        chk("t2_ovf", ovf0, 1);
        chk("t2_hold_word", w0, 8'hFF);
        chk("t2_hold_ones", o0, 8);
        chk("t2_valid", v0, 1);
        word_ready = 1'b1;
        step();
        chk("t2_drained", v0, 0);
        chk("t2_ovf_sticky", ovf0, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t2_clear_ovf", ovf0, 0);

        // Transfer coincident with completion: no bubble, no overflow
        word_ready = 1'b0;
        feed(8'hA5, 1'b1);
        chk("t3_valid_a5", v0, 1);
        v = 8'h3C;
        q0.push_back(v);
        q1.push_back(rev8(v));
        for (int i = 0; i < 8; i++) begin
            bit_en = 1'b1;
            bit_in = v[7-i];
            if (i == 7) word_ready = 1'b1;
            step();
            chk("t3_valid_hold", v0, 1);
        end
        bit_en = 1'b0;
        chk("t3_word_3c", w0, 8'h3C);
        chk("t3_ovf", ovf0, 0);
        step();
        chk("t3_drained", v0, 0);

        // Gapped bit_en: bits on every other cycle
        v = 8'hC3;
        early = 1'b0;
        q0.push_back(v);
        q1.push_back(rev8(v));
        for (int c = 0; c < 15; c++) begin
            bit_en = (c % 2 == 0);
            bit_in = v[7 - c/2];
            step();
            if (c < 14) early = early | v0;
            else chk("t4_valid", v0, 1);
        end
        bit_en = 1'b0;
        chk("t4_no_early_valid", early, 0);
        chk("t4_word", w0, 8'hC3);
        chk("t4_ones", o0, 4);
        step();

        // Async reset mid-word with a pending word
        word_ready = 1'b0;
        feed(8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bit_en = 1'b1;
            bit_in = 1'b1;
            step();
        end
        bit_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_word", w0, 0);
        chk("t5_rst_valid", v0, 0);
        chk("t5_rst_ones", o0, 0);
        flush_sb();
        @(posedge clk); #2 rst = 1'b0;
        step();
        word_ready = 1'b1;
        feed(8'h81, 1'b1);
        chk("t5_word", w0, 8'h81);
        chk("t5_ones", o0, 2);
        chk("t5_word_lsb", w1, 8'h81);
        step();

        // clear mid-word with a pending word and overflow set
        word_ready = 1'b0;
        feed(8'hF0, 1'b1);
        feed(8'h0F, 1'b0);
        chk("t6_ovf_set", ovf0, 1);
        for (int i = 0; i < 5; i++) begin
            bit_en = 1'b1;
            bit_in = 1'b1;
            step();
        end
        clear = 1'b1; bit_en = 1'b1; bit_in = 1'b1; word_ready = 1'b1;
        step();
        clear = 1'b0; bit_en = 1'b0;
        flush_sb();
        chk("t6_clr_valid", v0, 0);
        chk("t6_clr_word", w0, 0);
        chk("t6_clr_ones", o0, 0);
        chk("t6_clr_ovf", ovf0, 0);
        chk("t6_clr_ovf_lsb", ovf1, 0);
        feed(8'h81, 1'b1);
        chk("t6_word", w0, 8'h81);
        chk("t6_ones", o0, 2);
        step();
        chk("t6_drained", v0, 0);

        chk("sb_msb_leftover", q0.size(), 0);
        chk("sb_lsb_leftover", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
